pipe_robot_nav_ctrl: RTL and testbench

- Single-clock, parametrised navigation controller for the pipe cleaner robot.
- Replaces the clock-phase-divided sensor/orientation/advance chain with one sequencing FSM: sense, decide, turn, move, remove.
- Adds left- or right-hand wall-following mode, grid-bounded position tracking, a debris-removal counter and an action-count timeout.
- Sits between the sensor front-end and the motor/brush drivers.

---
 rtl/pipe_robot_nav_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_robot_nav_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_robot_nav_ctrl.sv
// Pipe-cleaner robot navigation controller: one sequencing FSM (sense, decide,
// turn, move, remove) with wall following, grid-bounded tracking and a timeout.
module pipe_robot_nav_ctrl #(
   parameter int GRID_W        = 16,
   parameter int GRID_H        = 16,
   parameter int COORD_W       = 4,
   parameter int HOME_X        = 0,
   parameter int HOME_Y        = 0,
   parameter int STEP_W        = 12,
   parameter int MAX_STEPS     = 1000,
   parameter int REMOVE_CYCLES = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               head,
   input  logic               side,
   input  logic               barreira,
   input  logic               under,
   output logic               avancar,
   output logic               girar,
   output logic               gir_dir,
   output logic               remover,
   output logic [1:0]         orientacao,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic [STEP_W-1:0]  step_count,
   output logic [7:0]         removed_count,
   output logic               bound_hit,
   output logic               busy,
   output logic               done,
   output logic               timeout
);
   localparam int              RC_W    = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(REMOVE_CYCLES - 1);
   localparam logic [1:0]      DIR_N   = 2'd0;
   localparam logic [1:0]      DIR_E   = 2'd1;
   localparam logic [1:0]      DIR_S   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_SENSE, S_DECIDE, S_TURN, S_MOVE, S_REMOVE, S_DONE, S_TIMEOUT
   } state_t;

   state_t          state, state_nxt;
   logic            mode_q, head_q, side_q, barreira_q, under_q;
   logic            turned_flag, turn_dir;
   logic [RC_W-1:0] rem_cnt;
   logic            ahead_ok, dec_turn_dir, dec_flag, dec_bound;

   // Next cell along the current heading still lies inside the grid.
   always_comb begin
      case (orientacao)
         DIR_N:   ahead_ok = pos_y < COORD_W'(GRID_H - 1);
         DIR_E:   ahead_ok = pos_x < COORD_W'(GRID_W - 1);
         DIR_S:   ahead_ok = pos_y != '0;
         default: ahead_ok = pos_x != '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_nxt    = state;
      dec_turn_dir = turn_dir;
      dec_flag     = 1'b0;
      dec_bound    = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_TIMEOUT: if (start) state_nxt = S_SENSE;
         S_SENSE: state_nxt = S_DECIDE;
         S_DECIDE: begin
            if (under_q) begin
               state_nxt = S_DONE;
            end else if (step_count == STEP_W'(MAX_STEPS)) begin
               state_nxt = S_TIMEOUT;
            end else if (!side_q && !turned_flag) begin
               state_nxt    = S_TURN;
               dec_turn_dir = mode_q;      // toward the followed side
               dec_flag     = 1'b1;
            end else if (head_q) begin
               state_nxt    = S_TURN;
               dec_turn_dir = ~mode_q;
            end else if (barreira_q) begin
               state_nxt = S_REMOVE;
            end else if (ahead_ok) begin
               state_nxt = S_MOVE;
            end else begin
               state_nxt    = S_TURN;
               dec_turn_dir = ~mode_q;
               dec_bound    = 1'b1;
            end
         end
         S_TURN, S_MOVE: state_nxt = S_SENSE;
         S_REMOVE: if (rem_cnt == RC_LAST) state_nxt = S_SENSE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q        <= 1'b0;
         head_q        <= 1'b0;
         side_q        <= 1'b0;
         barreira_q    <= 1'b0;
         under_q       <= 1'b0;
         turned_flag   <= 1'b0;
         turn_dir      <= 1'b0;
         rem_cnt       <= '0;
         orientacao    <= DIR_N;
         pos_x         <= COORD_W'(HOME_X);
         pos_y         <= COORD_W'(HOME_Y);
         step_count    <= '0;
         removed_count <= '0;
         bound_hit     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
               if (start) begin
                  mode_q        <= mode;
                  turned_flag   <= 1'b0;
                  orientacao    <= DIR_N;
                  pos_x         <= COORD_W'(HOME_X);
                  pos_y         <= COORD_W'(HOME_Y);
                  step_count    <= '0;
                  removed_count <= '0;
                  bound_hit     <= 1'b0;
               end
            end
            S_SENSE: begin
               head_q     <= head;
               side_q     <= side;
               barreira_q <= barreira;
               under_q    <= under;
            end
            S_DECIDE: begin
               turn_dir <= dec_turn_dir;
               rem_cnt  <= '0;
               if (dec_flag)  turned_flag <= 1'b1;
               if (dec_bound) bound_hit   <= 1'b1;
            end
            S_TURN: begin
               orientacao <= turn_dir ? orientacao + 2'd1 : orientacao - 2'd1;
               step_count <= step_count + STEP_W'(1);
            end
            S_MOVE: begin
               case (orientacao)
                  DIR_N:   pos_y <= pos_y + COORD_W'(1);
                  DIR_E:   pos_x <= pos_x + COORD_W'(1);
                  DIR_S:   pos_y <= pos_y - COORD_W'(1);
                  default: pos_x <= pos_x - COORD_W'(1);
               endcase
               step_count  <= step_count + STEP_W'(1);
               turned_flag <= 1'b0;
            end
            S_REMOVE: begin
               rem_cnt <= rem_cnt + RC_W'(1);
               if (rem_cnt == RC_LAST) begin
                  step_count <= step_count + STEP_W'(1);
                  if (removed_count != 8'hFF) removed_count <= removed_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign avancar = (state == S_MOVE);
   assign girar   = (state == S_TURN);
   assign gir_dir = girar & turn_dir;
   assign remover = (state == S_REMOVE);
   assign busy    = !(state inside {S_IDLE, S_DONE, S_TIMEOUT});
   assign done    = (state == S_DONE);
   assign timeout = (state == S_TIMEOUT);

endmodule

// File: tb/tb_pipe_robot_nav_ctrl.sv
// Directed bench for pipe_robot_nav_ctrl: default instance plus one with
// HOME=(8,8) and MAX_STEPS=4.
module tb_pipe_robot_nav_ctrl;
   logic clock = 1'b0;
   logic reset, start0, start1, mode, head, side, barreira, under;

   logic        avancar0, girar0, gir_dir0, remover0, bound_hit0, busy0, done0, timeout0;
   logic [1:0]  orient0;
   logic [3:0]  pos_x0, pos_y0;
   logic [11:0] steps0;
   logic [7:0]  removed0;

   logic        avancar1, girar1, gir_dir1, remover1, bound_hit1, busy1, done1, timeout1;
   logic [1:0]  orient1;
   logic [3:0]  pos_x1, pos_y1;
   logic [11:0] steps1;
   logic [7:0]  removed1;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pipe_robot_nav_ctrl u_dut0 (
      .clock(clock), .reset(reset), .start(start0), .mode(mode), .head(head),
      .side(side), .barreira(barreira), .under(under),
      .avancar(avancar0), .girar(girar0), .gir_dir(gir_dir0), .remover(remover0),
      .orientacao(orient0), .pos_x(pos_x0), .pos_y(pos_y0), .step_count(steps0),
      .removed_count(removed0), .bound_hit(bound_hit0), .busy(busy0),
      .done(done0), .timeout(timeout0)
   );

   pipe_robot_nav_ctrl #(.HOME_X(8), .HOME_Y(8), .MAX_STEPS(4)) u_dut1 (
      .clock(clock), .reset(reset), .start(start1), .mode(mode), .head(head),
      .side(side), .barreira(barreira), .under(under),
      .avancar(avancar1), .girar(girar1), .gir_dir(gir_dir1), .remover(remover1),
      .orientacao(orient1), .pos_x(pos_x1), .pos_y(pos_y1), .step_count(steps1),
      .removed_count(removed1), .bound_hit(bound_hit1), .busy(busy1),
      .done(done1), .timeout(timeout1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
   endtask

   // Leaves the bench one negedge after the start edge, i.e. in SENSE.
   task automatic pulse_start(input bit which);
      if (which) start1 = 1'b1;
      else       start0 = 1'b1;
      cycles(1);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
      mode = 1'b0; head = 1'b0; side = 1'b1; barreira = 1'b0; under = 1'b0;
      cycles(2);
      check("rst_busy",    busy0,   0);
      check("rst_done",    done0,   0);
      check("rst_orient",  orient0, 0);
      check("rst_pos_y0",  pos_y0,  0);
      check("rst_steps",   steps0,  0);
      check("rst_home_x1", pos_x1,  8);
      check("rst_home_y1", pos_y1,  8);
      reset = 1'b0;

      // Straight run north along a left wall
      pulse_start(0);
      check("t1_busy",      busy0,    1);
      check("t1_sense_adv", avancar0, 0);
      cycles(2);
      check("t1_adv1",      avancar0, 1);
      check("t1_y_pre",     pos_y0,   0);
      cycles(1);
      check("t1_gap",       avancar0, 0);
      check("t1_y1",        pos_y0,   1);
      cycles(2);
      check("t1_adv2",      avancar0, 1);
      cycles(1);
      check("t1_y2",        pos_y0,   2);
      check("t1_steps",     steps0,   2);
      pulse_start(0);
      check("t1_ign_steps", steps0,   2);
      check("t1_ign_y",     pos_y0,   2);
      cycles(1);
      check("t1_ign_adv",   avancar0, 1);

      // Lost wall on the followed side: turn toward it, then move (left rule)
      apply_reset();
      mode = 1'b0; side = 1'b0; head = 1'b0;
      pulse_start(1);
      cycles(2);
      check("t2l_girar",   girar1,   1);
      check("t2l_dir",     gir_dir1, 0);
      cycles(1);
      check("t2l_orient",  orient1,  3);
      cycles(2);
      check("t2l_adv",     avancar1, 1);
      cycles(1);
      check("t2l_x",       pos_x1,   7);
      check("t2l_y",       pos_y1,   8);
      // Same stimulus, right-hand rule
      apply_reset();
      mode = 1'b1;
      pulse_start(1);
      cycles(2);
      check("t2r_girar",   girar1,   1);
      check("t2r_dir",     gir_dir1, 1);
      cycles(1);
      check("t2r_orient",  orient1,  1);
      cycles(2);
      check("t2r_adv",     avancar1, 1);
      cycles(1);
      check("t2r_x",       pos_x1,   9);

      // One debris removal, then the move resumes
      apply_reset();
      mode = 1'b0; side = 1'b1; head = 1'b0; barreira = 1'b1;
      pulse_start(0);
      cycles(1);
      barreira = 1'b0;
      cycles(1);
      for (int i = 0; i < 3; i++) begin
         check("t3_remover", remover0, 1);
         check("t3_no_adv",  avancar0, 0);
         cycles(1);
      end
      check("t3_rem_off",  remover0, 0);
      check("t3_removed",  removed0, 1);
      check("t3_steps",    steps0,   1);
      cycles(2);
      check("t3_adv",      avancar0, 1);

      // Walk east to the grid edge; the blocked move becomes a cw turn
      apply_reset();
      mode = 1'b0; side = 1'b1; head = 1'b1;
      pulse_start(0);
      cycles(1);
      head = 1'b0;
      cycles(1);
      check("t4_turn_e",   girar0,   1);
      check("t4_turn_dir", gir_dir0, 1);
      cycles(1);
      check("t4_orient_e", orient0,  1);
      cycles(45);
      check("t4_edge_x",   pos_x0,   15);
      check("t4_edge_y",   pos_y0,   0);
      check("t4_bh_pre",   bound_hit0, 0);
      check("t4_steps",    steps0,   16);
      cycles(2);
      check("t4_no_adv",   avancar0, 0);
      check("t4_girar",    girar0,   1);
      check("t4_dir",      gir_dir0, 1);
      check("t4_bound",    bound_hit0, 1);
      check("t4_x_kept",   pos_x0,   15);
      cycles(1);
      check("t4_orient_s", orient0,  2);
      check("t4_steps2",   steps0,   17);

      // Boxed in: four turns exhaust MAX_STEPS=4
      apply_reset();
      mode = 1'b0; side = 1'b1; head = 1'b1;
      pulse_start(1);
      for (int k = 1; k <= 4; k++) begin
         cycles(2);
         check("t5_girar",  girar1,  1);
         cycles(1);
         check("t5_orient", orient1, k % 4);
      end
      cycles(2);
      check("t5_timeout",  timeout1, 1);
      check("t5_busy",     busy1,    0);
      check("t5_no_turn",  girar1,   0);
      check("t5_steps",    steps1,   4);
      cycles(3);
      check("t5_sticky",   timeout1, 1);
      pulse_start(1);
      check("t5_clear",    timeout1, 0);
      check("t5_busy2",    busy1,    1);
      check("t5_steps0",   steps1,   0);

      // Reset mid-removal, then an immediate exit
      apply_reset();
      mode = 1'b0; side = 1'b1; head = 1'b0; barreira = 1'b1; under = 1'b0;
      pulse_start(0);
      cycles(3);
      check("t6_rem_c2",   remover0, 1);
      reset = 1'b1;
      #1;
      check("t6_rem_rst",  remover0, 0);
      check("t6_busy_rst", busy0,    0);
      check("t6_cnt_rst",  removed0, 0);
      cycles(1);
      reset = 1'b0; barreira = 1'b0; under = 1'b1;
      pulse_start(0);
      cycles(1);
      check("t6_dec_adv",  avancar0, 0);
      cycles(1);
      check("t6_done",     done0,    1);
      check("t6_busy",     busy0,    0);
      check("t6_no_act",   {avancar0, girar0, remover0}, 0);
      cycles(2);
      check("t6_sticky",   done0,    1);
      pulse_start(0);
      check("t6_clear",    done0,    0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
